temp_entry: RTL and testbench

Keypad front end for the temperature monitor. Collects up to three BCD digits and a sign from single-cycle key strobes, then commits them as the current reading on ENTER. Computes the BCD magnitude difference from the previous reading with a multi-cycle digit-serial subtractor. Publishes reading, previous sign, difference, reading count and a one-cycle `got_value` strobe, the exact signal set consumed by the temperature state classifier downstream.

---
 rtl/temp_entry.sv | 229 ++++++++++++++++++++++
 tb/tb_temp_entry.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/temp_entry.sv
// temp_entry: keypad front end for the temperature monitor.
// Collects up to three BCD digits plus a sign from single-cycle key strobes,
// commits them as the current reading on ENTER, then forms |curr| - |prev|
// with a digit-serial BCD subtractor and pulses got_value when the result
// is published.
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous reset, active low
//   key_valid       one-cycle strobe qualifying key_code
//   key_code[3:0]   0-9 digit, A sign toggle, C clear, E enter
//   bcd_press[2:0]  digits held in the entry buffer (0..3)
//   curr_*_value    committed reading, BCD HT.O
//   curr_sign_mode  sign of committed reading (1 = negative)
//   temp_sign_mode  sign of previous reading
//   out_huns/tens/ones  |curr| - |prev| magnitude, BCD
//   diff_read[2:0]  readings committed, saturates at 2
//   got_value       one-cycle pulse, outputs valid
//   busy            commit/subtract in progress, keys dropped
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | accepting keys
// LOAD  | reading just committed (curr_* already updated)
// CMP   | order magnitudes into minuend / subtrahend
// SUB0  | subtract ones digit
// SUB1  | subtract tens digit
// SUB2  | subtract hundreds digit, publish out_*
// DONE  | got_value asserted for one cycle

module temp_entry (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [2:0] bcd_press,
    output logic [3:0] curr_huns_value,
    output logic [3:0] curr_tens_value,
    output logic [3:0] curr_ones_value,
    output logic       curr_sign_mode,
    output logic       temp_sign_mode,
    output logic [3:0] out_huns,
    output logic [3:0] out_tens,
    output logic [3:0] out_ones,
    output logic [2:0] diff_read,
    output logic       got_value,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CMP  = 3'd2,
        SUB0 = 3'd3,
        SUB1 = 3'd4,
        SUB2 = 3'd5,
        DONE = 3'd6
    } state_t;

    localparam logic [3:0] KEY_SIGN  = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hE;

    state_t state, state_next;

    logic [3:0]  entry_huns, entry_tens, entry_ones;
    logic        entry_sign;
    logic [11:0] prev_mag;
    logic [11:0] minuend, subtrahend;
    logic        borrow;
    logic [3:0]  res_ones, res_tens;

    logic        idle_key;
    logic        enter_ok;
    logic [11:0] curr_mag;
    logic [4:0]  sub_ones, sub_tens, sub_huns;

    // One BCD digit of a - b - bin; returns {borrow_out, digit}.
    function automatic logic [4:0] bcd_sub(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic       bin);
        logic [4:0] d;
        d = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
        if (d[4]) begin
            bcd_sub = {1'b1, d[3:0] + 4'd10};
        end else begin
            bcd_sub = {1'b0, d[3:0]};
        end
    endfunction

    assign idle_key = (state == IDLE) && key_valid;
    assign enter_ok = idle_key && (key_code == KEY_ENTER) && (bcd_press != 3'd0);
    assign curr_mag = {curr_huns_value, curr_tens_value, curr_ones_value};

    // borrow holds the carry from the previous digit stage at each step
    assign sub_ones = bcd_sub(minuend[3:0],  subtrahend[3:0],  1'b0);
    assign sub_tens = bcd_sub(minuend[7:4],  subtrahend[7:4],  borrow);
    assign sub_huns = bcd_sub(minuend[11:8], subtrahend[11:8], borrow);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        got_value  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (enter_ok) begin
                    state_next = LOAD;
                end
            end
            LOAD: state_next = CMP;
            CMP:  state_next = SUB0;
            SUB0: state_next = SUB1;
            SUB1: state_next = SUB2;
            SUB2: state_next = DONE;
            DONE: begin
                got_value  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_huns      <= 4'd0;
            entry_tens      <= 4'd0;
            entry_ones      <= 4'd0;
            entry_sign      <= 1'b0;
            bcd_press       <= 3'd0;
            curr_huns_value <= 4'd0;
            curr_tens_value <= 4'd0;
            curr_ones_value <= 4'd0;
            curr_sign_mode  <= 1'b0;
            temp_sign_mode  <= 1'b0;
            prev_mag        <= 12'd0;
            diff_read       <= 3'd0;
            minuend         <= 12'd0;
            subtrahend      <= 12'd0;
            borrow          <= 1'b0;
            res_ones        <= 4'd0;
            res_tens        <= 4'd0;
            out_huns        <= 4'd0;
            out_tens        <= 4'd0;
            out_ones        <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_key) begin
                        if (key_code <= 4'd9) begin
                            if (bcd_press < 3'd3) begin
                                entry_huns <= entry_tens;
                                entry_tens <= entry_ones;
                                entry_ones <= key_code;
                                bcd_press  <= bcd_press + 3'd1;
                            end
                        end else if (key_code == KEY_SIGN) begin
                            entry_sign <= ~entry_sign;
                        end else if (key_code == KEY_CLEAR) begin
                            entry_huns <= 4'd0;
                            entry_tens <= 4'd0;
                            entry_ones <= 4'd0;
                            entry_sign <= 1'b0;
                            bcd_press  <= 3'd0;
                        end else if (enter_ok) begin
                            // Commit lands on the accepting edge so curr_* are
                            // already visible during the LOAD cycle.
                            if (diff_read == 3'd0) begin
                                prev_mag       <= {entry_huns, entry_tens, entry_ones};
                                temp_sign_mode <= entry_sign;
                            end else begin
                                prev_mag       <= curr_mag;
                                temp_sign_mode <= curr_sign_mode;
                            end
                            curr_huns_value <= entry_huns;
                            curr_tens_value <= entry_tens;
                            curr_ones_value <= entry_ones;
                            curr_sign_mode  <= entry_sign;
                            if (diff_read != 3'd2) begin
                                diff_read <= diff_read + 3'd1;
                            end
                            entry_huns <= 4'd0;
                            entry_tens <= 4'd0;
                            entry_ones <= 4'd0;
                            entry_sign <= 1'b0;
                            bcd_press  <= 3'd0;
                        end
                    end
                end
                CMP: begin
                    // BCD digit order preserves numeric order, so a plain
                    // 12-bit compare picks the larger magnitude.
                    if (curr_mag >= prev_mag) begin
                        minuend    <= curr_mag;
                        subtrahend <= prev_mag;
                    end else begin
                        minuend    <= prev_mag;
                        subtrahend <= curr_mag;
                    end
                    borrow <= 1'b0;
                end
                SUB0: begin
                    res_ones <= sub_ones[3:0];
                    borrow   <= sub_ones[4];
                end
                SUB1: begin
                    res_tens <= sub_tens[3:0];
                    borrow   <= sub_tens[4];
                end
                SUB2: begin
                    out_ones <= res_ones;
                    out_tens <= res_tens;
                    out_huns <= sub_huns[3:0];
                    borrow   <= sub_huns[4];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_entry.sv
// tb_temp_entry: directed keypad sequences for temp_entry. A decimal-level
// reference model tracks the expected outputs; every cycle the DUT is
// compared against it, and literal expectations pin key results.

module tb_temp_entry;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [2:0] bcd_press;
    logic [3:0] curr_huns_value, curr_tens_value, curr_ones_value;
    logic       curr_sign_mode, temp_sign_mode;
    logic [3:0] out_huns, out_tens, out_ones;
    logic [2:0] diff_read;
    logic       got_value, busy;

    int checks = 0;
    int errors = 0;
    int got_seen = 0;

    temp_entry dut (
        .clk             (clk),
        .rst             (rst),
        .key_valid       (key_valid),
        .key_code        (key_code),
        .bcd_press       (bcd_press),
        .curr_huns_value (curr_huns_value),
        .curr_tens_value (curr_tens_value),
        .curr_ones_value (curr_ones_value),
        .curr_sign_mode  (curr_sign_mode),
        .temp_sign_mode  (temp_sign_mode),
        .out_huns        (out_huns),
        .out_tens        (out_tens),
        .out_ones        (out_ones),
        .diff_read       (diff_read),
        .got_value       (got_value),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (decimal arithmetic) ----------------
    int m_entry = 0, m_press = 0, m_esign = 0;
    int m_curr = 0, m_prev = 0, m_csign = 0, m_tsign = 0;
    int m_reads = 0, m_out = 0, m_pend = 0;
    int m_phase = 0;   // 0 idle, else cycles since ENTER accepted (1..6)

    function automatic int to_bcd(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_entry = 0; m_press = 0; m_esign = 0;
            m_curr = 0; m_prev = 0; m_csign = 0; m_tsign = 0;
            m_reads = 0; m_out = 0; m_pend = 0; m_phase = 0;
        end else if (m_phase != 0) begin
            if (m_phase == 6) begin
                m_phase = 0;
            end else begin
                m_phase = m_phase + 1;
                if (m_phase == 6) m_out = m_pend;
            end
        end else if (key_valid) begin
            if (key_code <= 4'd9) begin
                if (m_press < 3) begin
                    m_entry = (m_entry * 10 + int'(key_code)) % 1000;
                    m_press = m_press + 1;
                end
            end else if (key_code == 4'hA) begin
                m_esign = 1 - m_esign;
            end else if (key_code == 4'hC) begin
                m_entry = 0; m_press = 0; m_esign = 0;
            end else if (key_code == 4'hE && m_press > 0) begin
                if (m_reads == 0) begin
                    m_prev = m_entry; m_tsign = m_esign;
                end else begin
                    m_prev = m_curr; m_tsign = m_csign;
                end
                m_curr  = m_entry;
                m_csign = m_esign;
                if (m_reads < 2) m_reads = m_reads + 1;
                m_pend  = (m_curr >= m_prev) ? m_curr - m_prev : m_prev - m_curr;
                m_entry = 0; m_press = 0; m_esign = 0;
                m_phase = 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("bcd_press", int'(bcd_press), m_press);
        chk("curr", int'({curr_huns_value, curr_tens_value, curr_ones_value}), to_bcd(m_curr));
        chk("curr_sign", int'(curr_sign_mode), m_csign);
        chk("temp_sign", int'(temp_sign_mode), m_tsign);
        chk("out", int'({out_huns, out_tens, out_ones}), to_bcd(m_out));
        chk("diff_read", int'(diff_read), m_reads);
        chk("got_value", int'(got_value), (m_phase == 6) ? 1 : 0);
        chk("busy", int'(busy), (m_phase != 0) ? 1 : 0);
        if (got_value) got_seen++;
    end

    // ---------------- stimulus ----------------
    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int curr_now();
        return int'({curr_huns_value, curr_tens_value, curr_ones_value});
    endfunction

    function automatic int out_now();
        return int'({out_huns, out_tens, out_ones});
    endfunction

    initial begin
        rst = 1'b0;
        idle(3);
        chk("lit_reset_curr", curr_now(), 'h000);
        chk("lit_reset_out", out_now(), 'h000);
        chk("lit_reset_busy", int'(busy), 0);
        rst = 1'b1;
        idle(1);

        // first reading 45.2
        press(4'd4); press(4'd5); press(4'd2);
        chk("lit_press3", int'(bcd_press), 3);
        press(4'hE);
        chk("lit_busy_load", int'(busy), 1);
        idle(7);
        chk("lit_first_curr", curr_now(), 'h452);
        chk("lit_first_out", out_now(), 'h000);
        chk("lit_first_reads", int'(diff_read), 1);
        chk("lit_first_got", got_seen, 1);

        // 40.0
        press(4'd4); press(4'd0); press(4'd0); press(4'hE); idle(7);
        chk("lit_400_curr", curr_now(), 'h400);
        chk("lit_400_out", out_now(), 'h052);
        chk("lit_400_reads", int'(diff_read), 2);

        // borrow chain
        press(4'd4); press(4'd0); press(4'd1); press(4'hE); idle(7);
        press(4'd3); press(4'd9); press(4'd8); press(4'hE); idle(7);
        chk("lit_borrow_out", out_now(), 'h003);
        press(4'd5); press(4'd0); press(4'd0); press(4'hE); idle(7);
        chk("lit_500_out", out_now(), 'h102);
        chk("lit_500_reads", int'(diff_read), 2);

        // overflow digit ignored
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        chk("lit_press_hold", int'(bcd_press), 3);
        press(4'hE); idle(7);
        chk("lit_123_curr", curr_now(), 'h123);
        chk("lit_123_out", out_now(), 'h377);

        // empty enter and ignored codes
        press(4'hE);
        chk("lit_empty_enter_busy", int'(busy), 0);
        press(4'hB); press(4'hD); press(4'hF);
        chk("lit_ignored_press", int'(bcd_press), 0);
        idle(7);
        chk("lit_empty_enter_got", got_seen, 6);
        press(4'd7); press(4'd7); press(4'hC);
        chk("lit_clear_press", int'(bcd_press), 0);

        // sign handling and keys dropped while busy
        press(4'd4); press(4'd5); press(4'd2); press(4'hE); idle(7);
        press(4'hA); press(4'd0); press(4'd5); press(4'd0); press(4'hE);
        press(4'd9); press(4'hE); idle(5);
        chk("lit_sign_curr", curr_now(), 'h050);
        chk("lit_sign_csign", int'(curr_sign_mode), 1);
        chk("lit_sign_tsign", int'(temp_sign_mode), 0);
        chk("lit_sign_out", out_now(), 'h402);
        chk("lit_drop_press", int'(bcd_press), 0);

        // reset in the middle of a commit
        press(4'd1); press(4'd1); press(4'd1); press(4'hE);
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("lit_midrst_curr", curr_now(), 'h000);
        chk("lit_midrst_out", out_now(), 'h000);
        chk("lit_midrst_reads", int'(diff_read), 0);
        chk("lit_midrst_busy", int'(busy), 0);
        idle(2);
        rst = 1'b1;
        idle(8);
        chk("lit_midrst_nogot", got_seen, 8);
        press(4'd6); press(4'd6); press(4'd6); press(4'hE); idle(7);
        chk("lit_after_curr", curr_now(), 'h666);
        chk("lit_after_out", out_now(), 'h000);
        chk("lit_after_reads", int'(diff_read), 1);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
